// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl - instruction-fetch sequencer
//
// Drives one outstanding request/acknowledge fetch to instruction memory for
// the address held in the external pc register. It computes the next pc
// (sequential, branch/jump redirect, or exception redirect) and hands each
// fetched word to the IF/ID stage. It also absorbs memory latency and
// downstream hazard stalls.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   pc            current pc register value
//   npc, stallF   next pc and hold request for the pc register
//   stallD        IF/ID hazard stall
//   br_taken/br_target, exc_req/exc_vector  redirect requests (pulses)
//   imem_req/imem_addr/imem_ack/imem_rdata  instruction memory handshake
//   instr, instr_valid, flushD              IF/ID interface
//
// npc, stallF, instr, instr_valid and flushD are combinational from the state
// and inputs. The pc register samples npc at the next edge.
// ============================================================================
module fetch_ctrl #(
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  PC_BASE = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  npc,
    output logic              stallF,
    input  logic              stallD,
    input  logic              br_taken,
    input  logic [WIDTH-1:0]  br_target,
    input  logic              exc_req,
    input  logic [WIDTH-1:0]  exc_vector,
    output logic              imem_req,
    output logic [WIDTH-1:0]  imem_addr,
    input  logic              imem_ack,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic [WIDTH-1:0]  instr,
    output logic              instr_valid,
    output logic              flushD
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Clears the two low address bits of a redirect target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};
    localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'd4};

    logic [1:0]        state_r, state_nx_s;
    logic              pend_v_r, pend_v_nx_s;
    logic              pend_exc_r, pend_exc_nx_s;   // pending redirect is an exception
    logic [WIDTH-1:0]  pend_tgt_r, pend_tgt_nx_s;
    logic [WIDTH-1:0]  buf_r, buf_nx_s;

    logic              redir_s;
    logic [WIDTH-1:0]  redir_tgt_s;
    logic [WIDTH-1:0]  seq_pc_s;

    // Redirect arbitration: an exception always beats a branch.
    always_comb begin
        redir_s     = exc_req | br_taken;
        redir_tgt_s = (exc_req ? exc_vector : br_target) & ALIGN_MASK;
        seq_pc_s    = pc + PC_STEP;
    end

    // The request address always tracks pc. pc is held while a request waits,
    // so the address stays stable until the ack.
    assign imem_addr = pc;

    // Next-state and output decode.
    always_comb begin
        state_nx_s    = state_r;
        pend_v_nx_s   = pend_v_r;
        pend_exc_nx_s = pend_exc_r;
        pend_tgt_nx_s = pend_tgt_r;
        buf_nx_s      = buf_r;
        npc           = pc;
        stallF        = 1'b1;
        imem_req      = 1'b0;
        instr         = {WIDTH{1'b0}};
        instr_valid   = 1'b0;
        flushD        = 1'b0;

        case (state_r)
            IDLE: begin
                // IDLE is only reachable from reset, where pc equals PC_BASE.
                npc        = PC_BASE;
                state_nx_s = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                instr    = imem_rdata;
                flushD   = redir_s;
                if (!imem_ack) begin
                    // Remember a redirect until the outstanding word returns.
                    if (exc_req) begin
                        pend_v_nx_s   = 1'b1;
                        pend_exc_nx_s = 1'b1;
                        pend_tgt_nx_s = redir_tgt_s;
                    end else if (br_taken) begin
                        if (!(pend_v_r && pend_exc_r)) begin
                            pend_v_nx_s   = 1'b1;
                            pend_tgt_nx_s = redir_tgt_s;
                        end else begin
                            pend_v_nx_s   = pend_v_r;
                        end
                    end else begin
                        pend_v_nx_s = pend_v_r;
                    end
                end else if (pend_v_r || redir_s) begin
                    // Returned word belongs to the wrong path: squash it.
                    stallF        = 1'b0;
                    npc           = redir_s ? redir_tgt_s : pend_tgt_r;
                    pend_v_nx_s   = 1'b0;
                    pend_exc_nx_s = 1'b0;
                end else if (stallD) begin
                    buf_nx_s   = imem_rdata;
                    state_nx_s = HOLD;
                end else begin
                    instr_valid = 1'b1;
                    npc         = seq_pc_s;
                    stallF      = 1'b0;
                end
            end

            HOLD: begin
                instr  = buf_r;
                flushD = redir_s;
                if (redir_s) begin
                    stallF     = 1'b0;
                    npc        = redir_tgt_s;
                    state_nx_s = FETCH;
                end else if (stallD) begin
                    stallF = 1'b1;
                end else begin
                    instr_valid = 1'b1;
                    npc         = seq_pc_s;
                    stallF      = 1'b0;
                    state_nx_s  = FETCH;
                end
            end

            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            pend_v_r   <= 1'b0;
            pend_exc_r <= 1'b0;
            pend_tgt_r <= {WIDTH{1'b0}};
            buf_r      <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            pend_v_r   <= pend_v_nx_s;
            pend_exc_r <= pend_exc_nx_s;
            pend_tgt_r <= pend_tgt_nx_s;
            buf_r      <= buf_nx_s;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl - directed plus randomized bench for fetch_ctrl.
// The bench owns the pc register and an instruction memory whose word for an
// address is a fixed hash of that address. A cycle-level behavioural model
// (fetching / holding / pending-redirect) predicts every output.
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] PC_BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        stallF;
    logic        stallD;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flushD;

    int checks = 0;
    int errors = 0;

    // Model state: started (left the post-reset cycle), holding a word,
    // pending redirect, expected pc.
    logic        m_active, m_hold, m_pend_v, m_pend_exc;
    logic [31:0] m_hold_word, m_pend_tgt, m_pc;
    logic        n_active, n_hold, n_pend_v, n_pend_exc;
    logic [31:0] n_hold_word, n_pend_tgt, n_pc;

    fetch_ctrl #(.WIDTH(32), .PC_BASE(PC_BASE)) dut (
        .clk(clk), .rst(rst), .pc(pc), .npc(npc), .stallF(stallF),
        .stallD(stallD), .br_taken(br_taken), .br_target(br_target),
        .exc_req(exc_req), .exc_vector(exc_vector), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .flushD(flushD)
    );

    always #5 clk = ~clk;

    // The pc register the controller steers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= PC_BASE;
        else     pc <= npc;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_hold = 1'b0; m_pend_v = 1'b0; m_pend_exc = 1'b0;
        m_hold_word = 32'd0; m_pend_tgt = 32'd0; m_pc = PC_BASE;
    endtask

    // Drive one cycle's inputs, predict and check the outputs.
    task automatic apply(input logic ack, input logic sd, input logic br,
                         input logic [31:0] bt, input logic exc, input logic [31:0] ev);
        logic        red, e_stall, e_req, e_valid, e_flush;
        logic [31:0] tgt, e_npc, e_instr;
        imem_ack = ack; stallD = sd; br_taken = br; br_target = bt;
        exc_req = exc; exc_vector = ev; imem_rdata = word_of(m_pc);
        #1;
        red = exc | br;
        tgt = (exc ? ev : bt) & 32'hFFFF_FFFC;
        e_stall = 1'b1; e_npc = m_pc; e_req = 1'b0; e_valid = 1'b0;
        e_flush = 1'b0; e_instr = 32'd0;
        n_active = m_active; n_hold = m_hold; n_hold_word = m_hold_word;
        n_pend_v = m_pend_v; n_pend_exc = m_pend_exc; n_pend_tgt = m_pend_tgt;
        if (!m_active) begin
            n_active = 1'b1;
        end else if (m_hold) begin
            e_flush = red;
            if (red) begin
                e_stall = 1'b0; e_npc = tgt; n_hold = 1'b0;
            end else if (!sd) begin
                e_stall = 1'b0; e_npc = m_pc + 32'd4; e_valid = 1'b1;
                e_instr = m_hold_word; n_hold = 1'b0;
            end
        end else begin
            e_req = 1'b1; e_flush = red;
            if (!ack) begin
                if (exc) begin
                    n_pend_v = 1'b1; n_pend_exc = 1'b1; n_pend_tgt = tgt;
                end else if (br && !(m_pend_v && m_pend_exc)) begin
                    n_pend_v = 1'b1; n_pend_tgt = tgt;
                end
            end else if (m_pend_v || red) begin
                e_stall = 1'b0; e_npc = red ? tgt : m_pend_tgt;
                n_pend_v = 1'b0; n_pend_exc = 1'b0;
            end else if (sd) begin
                n_hold = 1'b1; n_hold_word = word_of(m_pc);
            end else begin
                e_stall = 1'b0; e_npc = m_pc + 32'd4; e_valid = 1'b1;
                e_instr = word_of(m_pc);
            end
        end
        n_pc = e_npc;
        chk("stallF", {31'd0, stallF}, {31'd0, e_stall});
        chk("npc", npc, e_npc);
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        chk("flushD", {31'd0, flushD}, {31'd0, e_flush});
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        if (e_valid) chk("instr", instr, e_instr);
    endtask

    // Commit the model and advance one clock.
    task automatic tick();
        m_active = n_active; m_hold = n_hold; m_hold_word = n_hold_word;
        m_pend_v = n_pend_v; m_pend_exc = n_pend_exc; m_pend_tgt = n_pend_tgt;
        m_pc = n_pc;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; stallD = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        exc_req = 1'b0; exc_vector = 32'd0; imem_rdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        // Reset values.
        chk("rst_stallF", {31'd0, stallF}, 32'd1);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_flushD", {31'd0, flushD}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_npc", npc, PC_BASE);
        chk("rst_addr", imem_addr, PC_BASE);
        rst = 1'b0;
        model_reset();

        // Zero-wait memory: one idle cycle, then one word per cycle.
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("zw_addr", imem_addr, 32'h3000 + 32'(i) * 32'd4);
            chk("zw_valid", {31'd0, instr_valid}, 32'd1);
            tick();
        end

        // Three-cycle ack latency at 0x3010.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("wait_stallF", {31'd0, stallF}, 32'd1);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("lat_valid", {31'd0, instr_valid}, 32'd1);
        chk("lat_npc", npc, 32'h3014);
        tick();

        // Branch during a wait, squashed return.
        apply(1'b0, 1'b0, 1'b1, 32'h3101, 1'b0, 32'd0);
        chk("br_flush", {31'd0, flushD}, 32'd1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("br_squash", {31'd0, instr_valid}, 32'd0);
        chk("br_npc", npc, 32'h3100);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("br_addr", imem_addr, 32'h3100);
        tick();

        // Exception beats branch, same cycle and across a wait.
        apply(1'b1, 1'b0, 1'b1, 32'h3200, 1'b1, 32'h4180);
        chk("exc_same", npc, 32'h4180);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4180);
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 32'd0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("exc_pend", npc, 32'h4180);
        tick();

        // Downstream stall at ack for two cycles.
        apply(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("sd_stallF", {31'd0, stallF}, 32'd1);
        tick();
        apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_stallF", {31'd0, stallF}, 32'd1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, word_of(32'h4180));
        chk("hold_npc", npc, 32'h4184);
        tick();

        // Wrap at the top of the address space.
        apply(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        tick();
        apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("wrap_npc", npc, 32'd0);
        tick();

        // Reset while waiting for memory.
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_npc", npc, 32'h3000);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic        r_ack, r_sd, r_br, r_exc;
            logic [31:0] r_bt, r_ev;
            r_ack = ($urandom_range(0, 1) == 0);
            r_sd  = ($urandom_range(0, 2) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_exc = ($urandom_range(0, 15) == 0);
            r_bt  = $urandom;
            r_ev  = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd_rst_req", {31'd0, imem_req}, 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
            end else begin
                apply(r_ack, r_sd, r_br, r_bt, r_exc, r_ev);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the `pc` register. Each cycle it computes `npc` and `stallF` for `pc` and drives a single-outstanding request/acknowledge handshake to instruction memory. It hands fetched words to the IF/ID stage. It arbitrates between three sources of the next PC: sequential increment, branch/jump redirect and exception redirect. It also absorbs variable memory latency and downstream hazard stalls.

## Interface
- `WIDTH`, 32, address/data width
- `PC_BASE`, 32'h0000_3000, reset PC (must equal the `pc` register reset value)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  WIDTH  current value of `pc` register
- `npc`  out  WIDTH  next PC to `pc` register
- `stallF`  out  1  hold `pc` register
- `stallD`  in  1  hazard-unit stall of IF/ID
- `br_taken`  in  1  branch/jump redirect request (single-cycle pulse)
- `br_target`  in  WIDTH  redirect address
- `exc_req`  in  1  exception redirect request (single-cycle pulse)
- `exc_vector`  in  WIDTH  exception handler address
- `imem_req`  out  1  instruction memory request
- `imem_addr`  out  WIDTH  request address
- `imem_ack`  in  1  memory data valid; may assert in the same cycle as `imem_req`
- `imem_rdata`  in  WIDTH  instruction word
- `instr`  out  WIDTH  instruction to IF/ID
- `instr_valid`  out  1  `instr` is a valid, non-squashed instruction
- `flushD`  out  1  squash IF/ID contents

## Operation
- **States.** IDLE, FETCH, HOLD.
- **Registers.**
  - `pend_v`, `pend_tgt`: a redirect captured while waiting for memory.
  - `buf`: the held instruction.
- **Redirect arbitration.**
  - Effective redirect this cycle = `exc_req` ? `exc_vector` : `br_taken` ? `br_target`.
  - Bits [1:0] of any redirect target are forced to 0.
  - Sequential next = `pc` + 4, modulo 2^WIDTH (wraps from 32'hFFFF_FFFC to 0).
- **`flushD`** = `br_taken | exc_req` in FETCH or HOLD; it is 0 in IDLE.
- **IDLE.** Entered on reset.
  - Outputs: `stallF`=1, `imem_req`=0, `instr_valid`=0.
  - Transitions to FETCH on the next clock.
- **FETCH.** `imem_req`=1 and `imem_addr`=`pc`.
  - **`imem_ack`=0:** `stallF`=1, `instr_valid`=0.
    - A redirect in this cycle sets `pend_v` and `pend_tgt`.
    - A later redirect overwrites `pend_tgt`, except that a branch never overwrites a pending exception.
  - **`imem_ack`=1 with `pend_v` set or a redirect this cycle:**
    - The returned word is discarded and `instr_valid`=0.
    - `npc` = this-cycle redirect target if present (exception first), else `pend_tgt`.
    - `stallF`=0; `pend_v` is cleared.
    - Stay in FETCH.
  - **`imem_ack`=1, `stallD`=1:** `buf`←`imem_rdata`, `stallF`=1, `instr_valid`=0; go to HOLD.
  - **`imem_ack`=1, `stallD`=0:**
    - `instr`=`imem_rdata`, `instr_valid`=1, `npc`=`pc`+4, `stallF`=0.
    - Stay in FETCH.
- **HOLD.** `imem_req`=0, `instr`=`buf`.
  - **Redirect:** `buf` is dropped, `instr_valid`=0, `npc`=target, `stallF`=0; go to FETCH.
  - **Else `stallD`=1:** `stallF`=1, `instr_valid`=0.
  - **Else:** `instr_valid`=1, `npc`=`pc`+4, `stallF`=0; go to FETCH.
- **Default `npc`.** When `stallF`=1, `npc`=`pc`.

## Timing
- **Reset values.**
  - State=IDLE, `pend_v`=0, `pend_tgt`=0, `buf`=0.
  - Outputs: `npc`=`PC_BASE`, `stallF`=1, `imem_req`=0, `imem_addr`=`pc`, `instr`=0, `instr_valid`=0, `flushD`=0.
- **Reset mid-operation.** An outstanding request is abandoned. Memory must tolerate `imem_req` dropping without an ack.
- **Fetch rate.**
  - Zero-wait memory (ack in the request cycle) gives 1 instruction/cycle.
  - An N-cycle ack gives 1 instruction per N+1 cycles.
- **Output timing.**
  - `npc`, `stallF`, `instr`, `instr_valid` and `flushD` are combinational from state and inputs.
  - `pc` updates at the next edge.
- **Request stability.** `imem_req` and `imem_addr` stay stable from assertion until ack.
- **Outstanding limit.** At most one request is outstanding.

## Test plan
- **Reset then zero-wait memory, `imem_ack`=1 every cycle:** `instr_valid` is 0 for the first cycle after reset release, then 1 every cycle. `imem_addr` runs 0x3000, 0x3004, 0x3008…
- **Ack delayed 3 cycles at `pc`=0x3010:** `stallF`=1 and `imem_req`=1 for 3 cycles. In the ack cycle `instr_valid`=1 and `npc`=0x3014.
- **`br_taken` with target 0x3101 during a wait, ack 2 cycles later:**
  - `flushD` pulses in the branch cycle.
  - The returned word is squashed (`instr_valid`=0) and `npc`=0x3100.
  - The next `imem_addr` is 0x3100.
- **Same-cycle `exc_req` (vector 0x4180) and `br_taken` (0x3200) with ack=1:** `npc`=0x4180. Repeat with the branch arriving one cycle after the exception while waiting: `npc` is still 0x4180.
- **`stallD`=1 for 2 cycles at ack:**
  - State goes to HOLD; `imem_req`=0, `stallF`=1.
  - On `stallD` release: `instr`=buffered word, `instr_valid`=1, `npc`=`pc`+4.
- **Wrap and mid-wait reset:**
  - At `pc`=0xFFFF_FFFC with ack, `npc`=0.
  - Asserting `rst` while waiting gives `imem_req`=0 immediately and `npc`=0x3000.
